ps2_key_receiver: RTL and testbench
===================================

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the number of idle system clocks mid-frame before the frame is aborted (1 ms at 50 MHz).
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port PS2_CLK, input, 1 bit: raw keyboard clock, asynchronous.
REQ-005 SHALL have port PS2_DAT, input, 1 bit: raw keyboard data, asynchronous.
REQ-006 SHALL have port ps2_key_data, output, 8 bits: make-code byte, valid while ps2_key_pressed is high.
REQ-007 SHALL have port ps2_key_pressed, output, 1 bit: one-cycle strobe per accepted make code.
REQ-008 SHALL have port last_data_received, output, 8 bits: the previously strobed make code.
REQ-009 SHALL have port key_extended, output, 1 bit: make code was preceded by 0xE0; valid with the strobe.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle strobe on a parity, stop-bit or timeout failure.

Function
REQ-011 SHALL pass PS2_CLK and PS2_DAT through 2-FF synchronizers; a frame bit is sampled on the cycle a synchronized PS2_CLK falling edge is detected.
REQ-012 SHALL decode the frame as: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
REQ-013 SHALL use FSM states IDLE, DATA, PARITY, STOP, DONE.
- IDLE -> DATA on a falling edge with DAT=0; a falling edge with DAT=1 stays in IDLE.
- DATA -> PARITY after 8 bits (3-bit counter).
- PARITY -> STOP on the next edge.
- STOP -> DONE on an edge with DAT=1; with DAT=0, go to IDLE and strobe frame_err.
- DONE -> IDLE after one cycle.
REQ-014 SHALL, in DONE, classify the byte:
- 0xF0: set break_pending, no strobe.
- 0xE0: set ext_pending, no strobe.
- Other byte with break_pending=1: clear both flags, no strobe; a release produces no output change.
- Other byte with break_pending=0: strobe.
REQ-015 SHALL, on a strobe, assert ps2_key_pressed for exactly one cycle, the cycle after DONE, with ps2_key_data = byte, key_extended = ext_pending, then clear ext_pending.
REQ-016 SHALL update last_data_received to the strobed byte on the cycle after the strobe, so it holds the prior make code during the strobe.
REQ-017 SHALL hold ps2_key_data and key_extended stable between strobes.
REQ-018 SHALL, in DATA/PARITY/STOP, increment a timeout counter each cycle without a falling edge and clear it on every edge; on reaching TIMEOUT_CYCLES, go to IDLE, strobe frame_err, and discard the partial byte and both pending flags.
REQ-019 SHALL give an edge detected in the DONE cycle no effect; IDLE resumes start detection on the next edge.
REQ-020 SHALL ensure a frame_err strobe never coincides with a ps2_key_pressed strobe for the same frame.

Reset
REQ-021 SHALL, on resetn=0, immediately force: state IDLE; ps2_key_data=0x00; last_data_received=0x00; ps2_key_pressed=0; key_extended=0; frame_err=0; both pending flags, the bit counter and the timeout counter=0; synchronizer flops=1.
REQ-022 SHALL discard a frame in progress when reset asserts mid-frame; the first frame after release decodes normally.

Configuration
REQ-023 SHALL, with macro PS2_PARITY_CHECK_EN defined, treat a parity mismatch in STOP as an error: go to IDLE, strobe frame_err, no classification.
REQ-024 SHALL, without PS2_PARITY_CHECK_EN, sample and ignore the parity bit; only stop-bit and timeout failures raise frame_err.

Structure
REQ-025 SHALL take from shared package ps2_pkg: the FSM state enum, SC_BREAK=8'hF0, SC_EXT=8'hE0, frame bit counts, and the make codes used by the game FSM (0x16, 0x1E, 0x26, 0x25, 0x15, 0x1D, 0x24, 0x2D, 0x1C, 0x1B).
REQ-026 SHALL contain one sub-module, ps2_sync: 2-FF synchronizer plus falling-edge detect for PS2_CLK, synchronized PS2_DAT output.

Verification
REQ-027 SHALL cover: frame 0x16, parity 0, stop 1 -> one strobe, ps2_key_data=0x16, key_extended=0, last_data_received=0x00 during the strobe and 0x16 one cycle later.
REQ-028 SHALL cover: frames 0x1C, then 0xF0, 0x1C -> exactly one strobe (0x1C); no output change on the release.
REQ-029 SHALL cover: frames 0xE0, 0x75 -> one strobe, data=0x75, key_extended=1; a following 0x16 gives key_extended=0.
REQ-030 SHALL cover: frame 0x16 with parity 1 -> with PS2_PARITY_CHECK_EN, frame_err pulses and no strobe; without it, strobe data=0x16.
REQ-031 SHALL cover: PS2_CLK stops after 4 data bits -> frame_err at TIMEOUT_CYCLES, then a clean 0x1B frame strobes 0x1B.
REQ-032 SHALL cover: resetn low for 3 cycles mid-frame -> all outputs 0 asynchronously, the next full 0x26 frame strobes 0x26.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, protocol prefix bytes, frame sizes and game make codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StDone
  } ps2_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;

  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_Q = 8'h15;
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_E = 8'h24;
  localparam logic [7:0] KEY_R = 8'h2D;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_S = 8'h1B;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the raw PS/2 lines plus falling-edge detect on the clock line.
module ps2_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_fall,
  output logic o_dat
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_prev;

  // Idle PS/2 lines are high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign o_clk_fall = r_clk_prev & ~r_clk_sync[1];
  assign o_dat      = r_dat_sync[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver with make/break/extended classification and frame timeout.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] last_data_received,
  output logic       key_extended,
  output logic       frame_err
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic w_clk_fall;
  logic w_dat;

  ps2_sync u_sync (
    .i_clk      (CLOCK_50),
    .i_rst_n    (resetn),
    .i_ps2_clk  (PS2_CLK),
    .i_ps2_dat  (PS2_DAT),
    .o_clk_fall (w_clk_fall),
    .o_dat      (w_dat)
  );

  ps2_state_e       r_state,     w_state_d;
  logic [2:0]       r_bit_cnt,   w_bit_cnt_d;
  logic [7:0]       r_shift,     w_shift_d;
  logic             r_parity,    w_parity_d;
  logic [ToW-1:0]   r_timeout,   w_timeout_d;
  logic [ToW-1:0]   w_timeout_inc;
  logic             r_break,     w_break_d;
  logic             r_ext,       w_ext_d;
  logic [7:0]       r_key_data,  w_key_data_d;
  logic             r_key_ext,   w_key_ext_d;
  logic             r_pressed,   w_pressed_d;
  logic [7:0]       r_last_data, w_last_data_d;
  logic             r_ferr,      w_ferr_d;

  always_comb begin
    w_state_d     = r_state;
    w_bit_cnt_d   = r_bit_cnt;
    w_shift_d     = r_shift;
    w_parity_d    = r_parity;
    w_timeout_d   = '0;
    w_break_d     = r_break;
    w_ext_d       = r_ext;
    w_key_data_d  = r_key_data;
    w_key_ext_d   = r_key_ext;
    w_pressed_d   = 1'b0;
    w_ferr_d      = 1'b0;
    w_last_data_d = r_pressed ? r_key_data : r_last_data;
    w_timeout_inc = r_timeout + ToW'(1);

    unique case (r_state)
      StIdle: begin
        w_bit_cnt_d = '0;
        if (w_clk_fall && !w_dat) w_state_d = StData;
      end
      StData, StParity, StStop: begin
        if (w_clk_fall) begin
          if (r_state == StData) begin
            w_shift_d   = {w_dat, r_shift[7:1]};
            w_bit_cnt_d = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) w_state_d = StParity;
          end else if (r_state == StParity) begin
            w_parity_d = w_dat;
            w_state_d  = StStop;
          end else if (!w_dat) begin
            w_ferr_d  = 1'b1;
            w_state_d = StIdle;
`ifdef PS2_PARITY_CHECK_EN
          end else if (!odd_parity_ok(r_shift, r_parity)) begin
            w_ferr_d  = 1'b1;
            w_state_d = StIdle;
`endif
          end else begin
            w_state_d = StDone;
          end
        end else if (w_timeout_inc == ToW'(TIMEOUT_CYCLES)) begin
          // Stalled keyboard: drop the partial byte and any pending prefix.
          w_state_d = StIdle;
          w_ferr_d  = 1'b1;
          w_shift_d = '0;
          w_break_d = 1'b0;
          w_ext_d   = 1'b0;
        end else begin
          w_timeout_d = w_timeout_inc;
        end
      end
      StDone: begin
        w_state_d = StIdle;
        if (r_shift == SC_BREAK) begin
          w_break_d = 1'b1;
        end else if (r_shift == SC_EXT) begin
          w_ext_d = 1'b1;
        end else if (r_break) begin
          w_break_d = 1'b0;
          w_ext_d   = 1'b0;
        end else begin
          w_pressed_d  = 1'b1;
          w_key_data_d = r_shift;
          w_key_ext_d  = r_ext;
          w_ext_d      = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_timeout   <= '0;
      r_break     <= 1'b0;
      r_ext       <= 1'b0;
      r_key_data  <= '0;
      r_key_ext   <= 1'b0;
      r_pressed   <= 1'b0;
      r_last_data <= '0;
      r_ferr      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shift     <= w_shift_d;
      r_parity    <= w_parity_d;
      r_timeout   <= w_timeout_d;
      r_break     <= w_break_d;
      r_ext       <= w_ext_d;
      r_key_data  <= w_key_data_d;
      r_key_ext   <= w_key_ext_d;
      r_pressed   <= w_pressed_d;
      r_last_data <= w_last_data_d;
      r_ferr      <= w_ferr_d;
    end
  end

  assign ps2_key_data       = r_key_data;
  assign ps2_key_pressed    = r_pressed;
  assign last_data_received = r_last_data;
  assign key_extended       = r_key_ext;
  assign frame_err          = r_ferr;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed scenarios plus random frames against a byte-level model.
module tb_ps2_key_receiver;
  import ps2_pkg::*;

  localparam int unsigned TO   = 300;
  localparam int unsigned HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [7:0] last_data_received;
  logic       key_extended;
  logic       frame_err;

  ps2_key_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50           (CLOCK_50),
    .resetn             (resetn),
    .PS2_CLK            (PS2_CLK),
    .PS2_DAT            (PS2_DAT),
    .ps2_key_data       (ps2_key_data),
    .ps2_key_pressed    (ps2_key_pressed),
    .last_data_received (last_data_received),
    .key_extended       (key_extended),
    .frame_err          (frame_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] data;
    logic       ext;
    logic [7:0] last_during;
    logic [7:0] last_after;
  } strobe_t;

  strobe_t strobes[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0, overlap_cnt = 0, long_cnt = 0, hold_viol = 0;

  // Byte-level model of the receiver's observable state.
  logic       m_brk = 1'b0, m_ext = 1'b0, m_kext = 1'b0;
  logic [7:0] m_last = 8'h00, m_key = 8'h00;

  initial begin : monitor
    strobe_t    cur;
    logic       after_pending = 1'b0, prev_pressed = 1'b0, prev_ext = 1'b0;
    logic [7:0] prev_data = 8'h00;
    cur = '0;
    forever begin
      @(negedge CLOCK_50);
      if (after_pending) begin
        cur.last_after = last_data_received;
        strobes.push_back(cur);
        after_pending = 1'b0;
      end
      if (ps2_key_pressed) begin
        cur.data        = ps2_key_data;
        cur.ext         = key_extended;
        cur.last_during = last_data_received;
        after_pending   = 1'b1;
        if (prev_pressed) long_cnt++;
        if (frame_err) overlap_cnt++;
      end else if (resetn && (ps2_key_data !== prev_data || key_extended !== prev_ext)) begin
        hold_viol++;
      end
      if (frame_err) ferr_cnt++;
      prev_pressed = ps2_key_pressed;
      prev_data    = ps2_key_data;
      prev_ext     = key_extended;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [FRAME_BITS-1:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = bits[i];
      repeat (10) @(posedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (HALF) @(posedge CLOCK_50);
      PS2_CLK = 1'b1;
      repeat (10) @(posedge CLOCK_50);
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par,
                          input bit bad_stop);
    int      n0, e0;
    bit      err, exp_strobe;
    logic    exp_ext;
    strobe_t s;
    n0 = strobes.size();
    e0 = ferr_cnt;
    send_frame(b, bad_par, bad_stop, FRAME_BITS);
    repeat (12) @(negedge CLOCK_50);
    err = bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    err = err | bad_par;
`endif
    exp_strobe = 1'b0;
    exp_ext    = 1'b0;
    if (!err) begin
      if (b == SC_BREAK) m_brk = 1'b1;
      else if (b == SC_EXT) m_ext = 1'b1;
      else if (m_brk) begin
        m_brk = 1'b0;
        m_ext = 1'b0;
      end else begin
        exp_strobe = 1'b1;
        exp_ext    = m_ext;
        m_ext      = 1'b0;
      end
    end
    check({tag, ".ferr"}, ferr_cnt - e0, {31'd0, err});
    check({tag, ".nstrobe"}, strobes.size() - n0, {31'd0, exp_strobe});
    if (exp_strobe && strobes.size() > n0) begin
      s = strobes[n0];
      check({tag, ".data"}, s.data, b);
      check({tag, ".ext"}, s.ext, exp_ext);
      check({tag, ".last_during"}, s.last_during, m_last);
      check({tag, ".last_after"}, s.last_after, b);
      m_last = b;
      m_key  = b;
      m_kext = exp_ext;
    end
    check({tag, ".hold_data"}, ps2_key_data, m_key);
    check({tag, ".hold_ext"}, key_extended, m_kext);
    check({tag, ".last"}, last_data_received, m_last);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".data"}, ps2_key_data, 8'h00);
    check({tag, ".pressed"}, ps2_key_pressed, 1'b0);
    check({tag, ".last"}, last_data_received, 8'h00);
    check({tag, ".ext"}, key_extended, 1'b0);
    check({tag, ".ferr"}, frame_err, 1'b0);
  endtask

  logic [7:0] codes [14];
  initial begin : stim
    int waited, e0, n0, found;
    codes = '{KEY_1, KEY_2, KEY_3, KEY_4, KEY_Q, KEY_W, KEY_E, KEY_R, KEY_A, KEY_S,
              SC_BREAK, SC_EXT, 8'h00, SC_BREAK};

    repeat (3) @(negedge CLOCK_50);
    check_outputs_zero("reset");
    resetn = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    do_frame("make16", KEY_1, 1'b0, 1'b0);
    do_frame("make1c", KEY_A, 1'b0, 1'b0);
    do_frame("brk_f0", SC_BREAK, 1'b0, 1'b0);
    do_frame("brk_1c", KEY_A, 1'b0, 1'b0);
    do_frame("ext_e0", SC_EXT, 1'b0, 1'b0);
    do_frame("ext_75", 8'h75, 1'b0, 1'b0);
    do_frame("after_ext_16", KEY_1, 1'b0, 1'b0);
    do_frame("badpar_16", KEY_1, 1'b1, 1'b0);
    do_frame("badstop_1e", KEY_2, 1'b0, 1'b1);

    // Stalled frame after a pending 0xE0: timeout must fire and discard the prefix.
    do_frame("pre_to_e0", SC_EXT, 1'b0, 1'b0);
    e0 = ferr_cnt;
    n0 = strobes.size();
    send_frame(8'h55, 1'b0, 1'b0, 5);
    waited = 0;
    found  = 0;
    while (waited < int'(TO) + 20 && found == 0) begin
      @(negedge CLOCK_50);
      waited++;
      if (ferr_cnt != e0) found = 1;
    end
    check("timeout.seen", ferr_cnt - e0, 32'd1);
    check("timeout.window", {31'd0, (waited >= int'(TO) - 35 && waited <= int'(TO) - 15)}, 32'd1);
    check("timeout.nostrobe", strobes.size() - n0, 32'd0);
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    do_frame("post_to_1b", KEY_S, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    do_frame("pre_rst_1e", KEY_2, 1'b0, 1'b0);
    send_frame(KEY_3, 1'b0, 1'b0, 5);
    @(posedge CLOCK_50);
    #2 resetn = 1'b0;
    #1 check_outputs_zero("async_rst");
    repeat (3) @(posedge CLOCK_50);
    #2 resetn = 1'b1;
    m_brk = 1'b0; m_ext = 1'b0; m_last = 8'h00; m_key = 8'h00; m_kext = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    do_frame("post_rst_26", KEY_3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = codes[$urandom_range(0, 13)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      do_frame("rand", b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
    end

    check("overlap_ferr_strobe", overlap_cnt, 32'd0);
    check("strobe_width", long_cnt, 32'd0);
    check("hold_between_strobes", hold_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
